sc_poly_eval_ctrl: RTL and testbench
====================================

SC_POLY_EVAL_CTRL -- requirements
Module: sc_poly_eval_ctrl

Interface
REQ-001 Parameter SHALL be: W, 8, binary operand width; stream length is 2^W cycles.
REQ-002 Port SHALL be: clk  input  1  single clock, all state on rising edge.
REQ-003 Port SHALL be: reset  input  1  asynchronous, active-high reset.
REQ-004 Port SHALL be: start  input  1  request one evaluation; sampled only in IDLE.
REQ-005 Port SHALL be: x_value  input  W  binary probability of x, latched on accepted start.
REQ-006 Port SHALL be: busy  output  1  high while in RUN.
REQ-007 Port SHALL be: done  output  1  one-cycle pulse when result is valid.
REQ-008 Port SHALL be: x_bits  output  3  independent stochastic copies of x, to the polynomial datapath.
REQ-009 Port SHALL be: r  output  6  random constant bits, to the polynomial datapath.
REQ-010 Port SHALL be: z_in  input  1  combinational stochastic output of the datapath, same cycle as x_bits/r.
REQ-011 Port SHALL be: result  output  W+1  count of z_in ones over one run, range 0..2^W.

Function
REQ-012 FSM SHALL have states IDLE, RUN, DONE; encoding free.
REQ-013 IDLE->RUN SHALL occur on the clock edge where start=1; x_value latched, all LFSRs reseeded, cycle counter and ones counter cleared on that edge.
REQ-014 start SHALL be ignored in RUN and DONE; no queuing.
REQ-015 RUN SHALL last exactly 2^W cycles; each RUN cycle samples z_in once into the ones counter (W+1 bits, no saturation needed).
REQ-016 RUN->DONE SHALL occur on the edge ending the 2^W-th sample; result loads the final count on that edge, including the last sample.
REQ-017 DONE SHALL last one cycle with done=1, then go to IDLE; result SHALL hold until the next RUN->DONE.
REQ-018 Three W-bit Fibonacci LFSRs (W=8: x^8+x^6+x^5+x^4+1), seeds 8'h01, 8'h5A, 8'hC3, SHALL advance once per RUN cycle; x_bits[i] = (lfsr_i < latched x_value), unsigned.
REQ-019 One 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seed 16'hACE1, SHALL advance once per RUN cycle; r = {l[15], l[12], l[9], l[6], l[3], l[0]}.
REQ-020 LFSRs SHALL hold in IDLE/DONE; x_bits SHALL be 0 outside RUN; r SHALL be 0 outside RUN.
REQ-021 LFSR updates SHALL be registered; x_bits and r SHALL derive combinationally from current LFSR state and latched x_value, so the first RUN cycle uses the seeds.
REQ-022 x_value changes after the accepting edge SHALL NOT affect the run in progress.

Reset
REQ-023 reset asserted SHALL immediately force IDLE, busy=0, done=0, result=0, x_bits=0, r=0, counters=0, LFSRs to seeds, latched x_value=0.
REQ-024 reset mid-RUN SHALL abort the run with no done pulse; first start after release begins a fresh run.
REQ-025 start coincident with reset deassertion edge SHALL be accepted only if reset is low at that edge.

Verification
REQ-026 start=1 one cycle, z_in tied 1 -> busy high exactly 256 cycles, done pulses once, result=256.
REQ-027 z_in tied 0, x_value=8'hFF -> result=0; x_bits[0] high on 255 of 256 RUN cycles.
REQ-028 x_value=128, monitor x_bits[0] -> exactly 128 ones over RUN (LFSR 1..255 plus seed repeat); x_value=0 -> x_bits all 0 whole run.
REQ-029 reset pulsed at RUN cycle 100 -> busy=0, no done, result=0; next start gives full 256-cycle run with seed-identical x_bits/r trace.
REQ-030 start held high continuously -> back-to-back runs separated by DONE+IDLE (2 cycles), extra starts during RUN ignored.
REQ-031 Datapath connected, x_value sweep 0..255 step 32 -> result within +/-24 of 256*golden-model polynomial value.

Source files
------------

// File: rtl/sc_poly_eval_ctrl_if.sv
// Handshake and datapath bundle between a requester and the stochastic polynomial evaluation controller.
interface sc_poly_eval_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] x_value;
  logic         busy;
  logic         done;
  logic [2:0]   x_bits;
  logic [5:0]   r;
  logic         z_in;
  logic [W:0]   result;

  modport master (
    output start, x_value, z_in,
    input  busy, done, x_bits, r, result
  );

  modport slave (
    input  start, x_value, z_in,
    output busy, done, x_bits, r, result
  );
endinterface

// File: rtl/sc_poly_eval_ctrl.sv
// Stochastic-computing polynomial evaluation controller: drives 2^W cycles of stochastic x copies and
// random constants into an external datapath and counts the ones it returns.
module sc_poly_eval_ctrl #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  sc_poly_eval_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // LFSR feedback taps correspond to x^8+x^6+x^5+x^4+1 when W=8
  localparam logic [W-1:0] SEED0 = W'(8'h01);
  localparam logic [W-1:0] SEED1 = W'(8'h5A);
  localparam logic [W-1:0] SEED2 = W'(8'hC3);
  localparam logic [15:0]  RSEED = 16'hACE1;

  state_e        state_q, state_d;
  logic [W-1:0]  xVal_q, xVal_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W:0]    ones_q, ones_d;
  logic [W:0]    result_q, result_d;
  logic [W-1:0]  lfsr_q [3];
  logic [W-1:0]  lfsr_d [3];
  logic [15:0]   rLfsr_q, rLfsr_d;
  logic [W:0]    zExt;

  function automatic logic [W-1:0] stepX(input logic [W-1:0] v);
    return {v[W-2:0], v[W-1] ^ v[W-3] ^ v[W-4] ^ v[W-5]};
  endfunction

  function automatic logic [15:0] stepR(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  assign zExt = (W+1)'(bus.z_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      xVal_q    <= '0;
      cnt_q     <= '0;
      ones_q    <= '0;
      result_q  <= '0;
      lfsr_q[0] <= SEED0;
      lfsr_q[1] <= SEED1;
      lfsr_q[2] <= SEED2;
      rLfsr_q   <= RSEED;
    end else begin
      state_q   <= state_d;
      xVal_q    <= xVal_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      result_q  <= result_d;
      lfsr_q[0] <= lfsr_d[0];
      lfsr_q[1] <= lfsr_d[1];
      lfsr_q[2] <= lfsr_d[2];
      rLfsr_q   <= rLfsr_d;
    end
  end

  // The final sample is folded into result on the same edge that leaves RUN
  always_comb begin
    state_d  = state_q;
    xVal_d   = xVal_q;
    cnt_d    = cnt_q;
    ones_d   = ones_q;
    result_d = result_q;
    lfsr_d   = lfsr_q;
    rLfsr_d  = rLfsr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          xVal_d    = bus.x_value;
          cnt_d     = '0;
          ones_d    = '0;
          lfsr_d[0] = SEED0;
          lfsr_d[1] = SEED1;
          lfsr_d[2] = SEED2;
          rLfsr_d   = RSEED;
        end
      end
      RUN: begin
        ones_d  = ones_q + zExt;
        cnt_d   = cnt_q + W'(1);
        for (int i = 0; i < 3; i++) begin
          lfsr_d[i] = stepX(lfsr_q[i]);
        end
        rLfsr_d = stepR(rLfsr_q);
        if (&cnt_q) begin
          state_d  = DONE;
          result_d = ones_q + zExt;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state_q == RUN);
    bus.done   = (state_q == DONE);
    bus.result = result_q;
    bus.x_bits = '0;
    bus.r      = '0;
    if (state_q == RUN) begin
      for (int i = 0; i < 3; i++) begin
        bus.x_bits[i] = (lfsr_q[i] < xVal_q);
      end
      bus.r = {rLfsr_q[15], rLfsr_q[12], rLfsr_q[9], rLfsr_q[6], rLfsr_q[3], rLfsr_q[0]};
    end
  end

endmodule

// File: tb/tb_sc_poly_eval_ctrl.sv
// Randomized self-checking bench for sc_poly_eval_ctrl with a small polynomial datapath and a run-level reference model.
module tb_sc_poly_eval_ctrl;
  localparam int W = 8;
  localparam int RUNLEN = 1 << W;

  logic clk = 1'b0;
  logic reset;
  int   zMode;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sc_poly_eval_ctrl_if #(.W(W)) bus ();

  sc_poly_eval_ctrl #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic bit modelZ(input int mode, input logic [2:0] xb, input logic [5:0] rb);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return rb[0] ? xb[0] : xb[1];
  endfunction

  // Datapath under test: r[0] picks between two x copies, evaluating p(x) = x
  always_comb begin
    bus.z_in = modelZ(zMode, bus.x_bits, bus.r);
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [7:0] nextX(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [15:0] nextR(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the following IDLE negedge.
  task automatic applyStimulus(input logic [W-1:0] xv, input bit hold,
                               output int busyCycles, output int x0Ones, output int expCount);
    logic [7:0]  m [3];
    logic [15:0] mr;
    logic [2:0]  ex;
    logic [5:0]  er;
    int guard;
    m[0] = 8'h01; m[1] = 8'h5A; m[2] = 8'hC3;
    mr = 16'hACE1;
    busyCycles = 0; x0Ones = 0; expCount = 0; guard = 0;
    bus.start = 1'b1;
    bus.x_value = xv;
    @(posedge clk);
    @(negedge clk);
    while (bus.busy === 1'b1 && guard < RUNLEN + 20) begin
      if (!hold) bus.start = 1'b0;
      bus.x_value = W'($urandom);
      for (int i = 0; i < 3; i++) ex[i] = (m[i] < xv);
      er = {mr[15], mr[12], mr[9], mr[6], mr[3], mr[0]};
      checkOutput("xBits", int'(bus.x_bits), int'(ex));
      checkOutput("rBits", int'(bus.r), int'(er));
      expCount += int'(modelZ(zMode, ex, er));
      x0Ones += int'(bus.x_bits[0]);
      busyCycles++;
      for (int i = 0; i < 3; i++) m[i] = nextX(m[i]);
      mr = nextR(mr);
      guard++;
      @(negedge clk);
    end
    if (!hold) bus.start = 1'b0;
    checkOutput("doneHigh", int'(bus.done), 1);
    checkOutput("result", int'(bus.result), expCount);
    @(negedge clk);
    checkOutput("doneOnePulse", int'(bus.done), 0);
    checkOutput("idleGap", int'(bus.busy), 0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bc, x0, ec, diff;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.x_value = '0;
    zMode = 1;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", int'(bus.busy), 0);
    checkOutput("rstDone", int'(bus.done), 0);
    checkOutput("rstResult", int'(bus.result), 0);
    checkOutput("rstXbits", int'(bus.x_bits), 0);
    checkOutput("rstR", int'(bus.r), 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] z_in tied high");
    applyStimulus(W'($urandom), 1'b0, bc, x0, ec);
    checkOutput("tie1Busy", bc, RUNLEN);
    checkOutput("tie1Result", int'(bus.result), RUNLEN);

    $display("[TB] z_in tied low, x extremes");
    zMode = 0;
    applyStimulus(8'hFF, 1'b0, bc, x0, ec);
    checkOutput("tie0Result", int'(bus.result), 0);
    checkOutput("xFFones", x0, 255);
    applyStimulus(8'd128, 1'b0, bc, x0, ec);
    checkOutput("x128ones", x0, 128);
    applyStimulus(8'd0, 1'b0, bc, x0, ec);
    checkOutput("x0ones", x0, 0);

    $display("[TB] start held high");
    zMode = 1;
    applyStimulus(W'($urandom), 1'b1, bc, x0, ec);
    checkOutput("heldBusy1", bc, RUNLEN);
    applyStimulus(W'($urandom), 1'b1, bc, x0, ec);
    checkOutput("heldBusy2", bc, RUNLEN);
    bus.start = 1'b0;
    @(negedge clk);

    $display("[TB] polynomial sweep");
    zMode = 2;
    for (int x = 0; x < 256; x += 32) begin
      applyStimulus(W'(x), 1'b0, bc, x0, ec);
      diff = int'(bus.result) - x;
      if (diff < 0) diff = -diff;
      checkOutput("polyTolerance", int'(diff <= 24), 1);
    end

    $display("[TB] reset during run");
    zMode = 1;
    bus.start = 1'b1;
    bus.x_value = 8'h77;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (99) @(negedge clk);
    checkOutput("midRunBusy", int'(bus.busy), 1);
    reset = 1'b1;
    #1;
    checkOutput("abortBusy", int'(bus.busy), 0);
    checkOutput("abortDone", int'(bus.done), 0);
    checkOutput("abortResult", int'(bus.result), 0);
    checkOutput("abortXbits", int'(bus.x_bits), 0);
    checkOutput("abortR", int'(bus.r), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("noDoneAfterAbort", int'(bus.done), 0);
    end
    applyStimulus(8'h77, 1'b0, bc, x0, ec);
    checkOutput("freshRunBusy", bc, RUNLEN);
    checkOutput("freshRunResult", int'(bus.result), RUNLEN);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
